// File: rtl/music_pkg.sv
// Shared note codes, half-period table and playback state encoding
// for the note recorder/player datapath.
package music_pkg;

    localparam int NOTE_W = 3;
    localparam int HP_W   = 17;

    typedef logic [NOTE_W-1:0] note_t;
    typedef logic [HP_W-1:0]   hp_t;

    localparam note_t REST = 3'd0;
    localparam note_t C4   = 3'd1;
    localparam note_t D4   = 3'd2;
    localparam note_t E4   = 3'd3;
    localparam note_t F4   = 3'd4;
    localparam note_t G4   = 3'd5;
    localparam note_t A4   = 3'd6;
    localparam note_t B4   = 3'd7;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        TONE
    } play_state_t;

    // Half-period in 50 MHz clock cycles; the shift shortens tones for simulation.
    function automatic hp_t note_half_period(input note_t code, input int unsigned shift);
        hp_t base;
        case (code)
            C4:      base = 17'd95556;
            D4:      base = 17'd85131;
            E4:      base = 17'd75843;
            F4:      base = 17'd71586;
            G4:      base = 17'd63776;
            A4:      base = 17'd56818;
            B4:      base = 17'd50619;
            default: base = '0;
        endcase
        return base >> shift;
    endfunction

endpackage

// File: rtl/note_player_if.sv
// Control-side bundle between the record/playback controller and note_player.
interface note_player_if #(
    parameter int AW     = 4,
    parameter int NOTE_W = 3
);
    logic              ld_note;
    logic [NOTE_W-1:0] note_in;
    logic              ld_play;
    logic [AW-1:0]     note_counter;
    logic              audio_out;
    logic [NOTE_W-1:0] cur_note;
    logic [AW:0]       wr_count;
    logic              full;

    modport master (
        output ld_note, note_in, ld_play, note_counter,
        input  audio_out, cur_note, wr_count, full
    );

    modport slave (
        input  ld_note, note_in, ld_play, note_counter,
        output audio_out, cur_note, wr_count, full
    );
endinterface

// File: rtl/note_player_tone_gen.sv
// Loadable half-period down-counter driving a toggle flop to make a square wave.
module tone_gen
    import music_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  hp_t  half_period,
    input  logic enable,
    output logic audio_out
);

    hp_t  r_count;
    logic r_audio;

    // The toggle lands on the cycle the count would reach zero, so the
    // output changes exactly every half_period enabled cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
            r_audio <= 1'b0;
        end else if (load) begin
            r_count <= half_period;
            r_audio <= 1'b0;
        end else if (enable) begin
            if (r_count <= hp_t'(1)) begin
                r_audio <= ~r_audio;
                r_count <= half_period;
            end else begin
                r_count <= r_count - hp_t'(1);
            end
        end
    end

    assign audio_out = r_audio;

endmodule

// File: rtl/note_player.sv
// Note memory, write pointer and playback FSM; the tone itself comes from tone_gen.
module note_player #(
    parameter int          DEPTH     = 16,
    parameter int          AW        = 4,
    parameter int          NOTE_W    = music_pkg::NOTE_W,
    parameter int unsigned DIV_SHIFT = 0
) (
    input logic         clk,
    input logic         reset,
    note_player_if.slave bus
);
    import music_pkg::*;

    logic [NOTE_W-1:0] r_mem [DEPTH];
    logic [AW:0]       r_wr_count;
    logic              r_ld_note_d;
    logic [NOTE_W-1:0] r_rd_note;
    logic [NOTE_W-1:0] r_cur_note;
    logic [AW-1:0]     r_idx;
    play_state_t       r_state;

    logic  w_full;
    logic  w_write;
    logic  w_load;
    logic  w_enable;
    note_t w_hp_note;
    hp_t   w_half_period;

    assign w_full  = (r_wr_count == (AW+1)'(DEPTH));
    assign w_write = bus.ld_note & ~r_ld_note_d & ~bus.ld_play & ~w_full;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_count  <= '0;
            r_ld_note_d <= 1'b0;
        end else begin
            r_ld_note_d <= bus.ld_note;
            if (w_write) begin
                r_mem[r_wr_count[AW-1:0]] <= bus.note_in;
                r_wr_count                <= r_wr_count + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_note <= '0;
        end else begin
            r_rd_note <= r_mem[bus.note_counter];
        end
    end

    // Dropping ld_play overrides everything, including a pending index change.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_cur_note <= '0;
            r_idx      <= '0;
        end else if (!bus.ld_play) begin
            r_state    <= IDLE;
            r_cur_note <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_state <= FETCH;
                    r_idx   <= bus.note_counter;
                end
                FETCH: begin
                    r_state    <= TONE;
                    r_cur_note <= r_rd_note;
                end
                TONE: begin
                    if (bus.note_counter != r_idx) begin
                        r_state <= FETCH;
                        r_idx   <= bus.note_counter;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Loading also clears the toggle flop, which silences the output on
    // entry to TONE and whenever playback stops.
    assign w_load        = ~bus.ld_play | (r_state == FETCH);
    assign w_enable      = (r_state == TONE) & (r_cur_note != '0);
    assign w_hp_note     = (r_state == FETCH) ? r_rd_note : r_cur_note;
    assign w_half_period = note_half_period(w_hp_note, DIV_SHIFT);

    tone_gen u_tone_gen (
        .clk         (clk),
        .reset       (reset),
        .load        (w_load),
        .half_period (w_half_period),
        .enable      (w_enable),
        .audio_out   (bus.audio_out)
    );

    assign bus.cur_note = r_cur_note;
    assign bus.wr_count = r_wr_count;
    assign bus.full     = w_full;

endmodule

// File: tb/tb_note_player.sv
// Self-checking bench for note_player: table-driven tone periods, hand-written
// corner sequences and randomized record/playback against a behavioural model.
module tb_note_player;

    localparam int AW    = 4;
    localparam int NW    = 3;
    localparam int DEPTH = 16;
    localparam int SHIFT = 10;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    note_player_if #(.AW(AW), .NOTE_W(NW)) bus ();

    note_player #(
        .DEPTH     (DEPTH),
        .AW        (AW),
        .NOTE_W    (NW),
        .DIV_SHIFT (SHIFT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NW-1:0] code;
        int            hp;
    } vec_t;

    vec_t vecs [8];

    int nChecks = 0;
    int nPass   = 0;

    // Behavioural model: notes stored in arrival order, counter of stored notes
    int            baseHp [8] = '{0, 95556, 85131, 75843, 71586, 63776, 56818, 50619};
    logic [NW-1:0] mdlMem [DEPTH];
    int            mdlCount;
    logic          prevLd;

    function automatic int expHp(input int code);
        return baseHp[code] >> SHIFT;
    endfunction

    function automatic logic expAudio(input int m, input int hp);
        if (hp == 0) return 1'b0;
        return ((m / hp) % 2) == 1;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end else begin
            nPass++;
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic mdlClear();
        for (int i = 0; i < DEPTH; i++) mdlMem[i] = '0;
        mdlCount = 0;
        prevLd   = 1'b0;
    endtask

    task automatic doReset();
        reset            = 1'b0;
        bus.ld_note      = 1'b0;
        bus.note_in      = '0;
        bus.ld_play      = 1'b0;
        bus.note_counter = '0;
        mdlClear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // One clock of control inputs; the model records on a rising ld_note edge.
    task automatic applyStimulus(input logic ldNote, input logic [NW-1:0] note,
                                 input logic ldPlay, input logic [AW-1:0] idx);
        bus.ld_note      = ldNote;
        bus.note_in      = note;
        bus.ld_play      = ldPlay;
        bus.note_counter = idx;
        if (ldNote && !prevLd && !ldPlay && mdlCount < DEPTH) begin
            mdlMem[mdlCount] = note;
            mdlCount++;
        end
        prevLd = ldNote;
        step(1);
    endtask

    // Leaves the DUT one edge into TONE for slot idx (tone cycle m = 0).
    task automatic playStart(input logic [AW-1:0] idx);
        bus.ld_play = 1'b0;
        step(1);
        bus.note_counter = idx;
        bus.ld_play      = 1'b1;
        step(2);
    endtask

    initial begin
        int highs;
        int hp;
        int win;
        int k;
        logic [AW-1:0] idx;

        vecs[0] = '{3'd1, 93};
        vecs[1] = '{3'd2, 83};
        vecs[2] = '{3'd3, 74};
        vecs[3] = '{3'd4, 69};
        vecs[4] = '{3'd5, 62};
        vecs[5] = '{3'd6, 55};
        vecs[6] = '{3'd7, 49};
        vecs[7] = '{3'd0, 0};

        doReset();
        checkOutput("reset_wr_count", bus.wr_count, 0);
        checkOutput("reset_full", bus.full, 0);
        checkOutput("reset_audio", bus.audio_out, 0);
        checkOutput("reset_cur_note", bus.cur_note, 0);

        // Record and hold: long pulse writes once, then a short one
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 3'd5, 1'b0, 4'd0);
        applyStimulus(1'b0, 3'd5, 1'b0, 4'd0);
        applyStimulus(1'b1, 3'd3, 1'b0, 4'd0);
        applyStimulus(1'b0, 3'd3, 1'b0, 4'd0);
        checkOutput("hold_wr_count", bus.wr_count, 2);

        // Playback of G4 with half-period 62
        playStart(4'd0);
        checkOutput("play_cur_note", bus.cur_note, 5);
        checkOutput("play_audio_m0", bus.audio_out, 0);
        for (int m = 1; m <= 130; m++) begin
            step(1);
            checkOutput($sformatf("play_audio_m%0d", m), bus.audio_out, expAudio(m, 62));
        end

        bus.note_counter = 4'd1;
        step(2);
        checkOutput("step_cur_note_mem1", bus.cur_note, 3);

        // Asynchronous reset while the tone is high
        k = 0;
        while (k < 200 && bus.audio_out !== 1'b1) begin
            step(1);
            k++;
        end
        checkOutput("audio_high_before_reset", bus.audio_out, 1);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async_reset_audio", bus.audio_out, 0);
        checkOutput("async_reset_cur_note", bus.cur_note, 0);
        checkOutput("async_reset_wr_count", bus.wr_count, 0);
        checkOutput("async_reset_full", bus.full, 0);
        bus.ld_play = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        mdlClear();

        // Index change onto an unwritten (rest) slot, then abort
        applyStimulus(1'b1, 3'd5, 1'b0, 4'd0);
        applyStimulus(1'b0, 3'd5, 1'b0, 4'd0);
        playStart(4'd0);
        checkOutput("rest_pre_cur_note", bus.cur_note, 5);
        step(30);
        bus.note_counter = 4'd1;
        step(2);
        checkOutput("rest_cur_note", bus.cur_note, 0);
        highs = 0;
        for (int m = 0; m < 200; m++) begin
            step(1);
            if (bus.audio_out !== 1'b0) highs++;
        end
        checkOutput("rest_audio_high_cycles", highs, 0);

        bus.note_counter = 4'd0;
        step(2);
        checkOutput("abort_pre_cur_note", bus.cur_note, 5);
        step(70);
        checkOutput("abort_pre_audio", bus.audio_out, expAudio(70, 62));
        bus.ld_play      = 1'b0;
        bus.note_counter = 4'd1;
        step(1);
        checkOutput("abort_cur_note", bus.cur_note, 0);
        checkOutput("abort_audio", bus.audio_out, 0);
        step(5);
        checkOutput("abort_stay_cur_note", bus.cur_note, 0);
        checkOutput("abort_stay_audio", bus.audio_out, 0);

        // Table-driven tone periods for every code
        doReset();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, vecs[i].code, 1'b0, 4'd0);
            applyStimulus(1'b0, vecs[i].code, 1'b0, 4'd0);
        end
        checkOutput("table_wr_count", bus.wr_count, 8);
        for (int i = 0; i < 8; i++) begin
            playStart(AW'(i));
            checkOutput($sformatf("table_cur_note_%0d", i), bus.cur_note, vecs[i].code);
            hp = vecs[i].hp;
            for (int m = 1; m <= ((hp == 0) ? 50 : 2 * hp); m++) begin
                step(1);
                if ((hp == 0 && m == 50) ||
                    (hp != 0 && (m == hp - 1 || m == hp || m == 2 * hp - 1 || m == 2 * hp))) begin
                    checkOutput($sformatf("table_audio_code%0d_m%0d", vecs[i].code, m),
                                bus.audio_out, (hp != 0 && m >= hp && m < 2 * hp) ? 1 : 0);
                end
            end
        end
        bus.ld_play = 1'b0;

        // Full saturation
        doReset();
        for (int p = 1; p <= 17; p++) begin
            applyStimulus(1'b1, 3'd1, 1'b0, 4'd0);
            applyStimulus(1'b0, 3'd1, 1'b0, 4'd0);
            if (p == 15) begin
                checkOutput("full_p15_wr_count", bus.wr_count, 15);
                checkOutput("full_p15_full", bus.full, 0);
            end
            if (p >= 16) begin
                checkOutput($sformatf("full_p%0d_wr_count", p), bus.wr_count, 16);
                checkOutput($sformatf("full_p%0d_full", p), bus.full, 1);
            end
        end

        // Record ignored while playing
        doReset();
        applyStimulus(1'b1, 3'd6, 1'b1, 4'd0);
        applyStimulus(1'b0, 3'd6, 1'b1, 4'd0);
        checkOutput("play_blocks_write", bus.wr_count, 0);
        applyStimulus(1'b0, 3'd6, 1'b0, 4'd0);

        // Randomized record traffic against the model
        doReset();
        for (int c = 0; c < 300; c++) begin
            applyStimulus(($urandom_range(0, 2) == 0) ? ~bus.ld_note : bus.ld_note,
                          NW'($urandom_range(0, 7)),
                          ($urandom_range(0, 9) == 0),
                          AW'($urandom_range(0, DEPTH - 1)));
            checkOutput("rand_wr_count", bus.wr_count, mdlCount);
            checkOutput("rand_full", bus.full, (mdlCount == DEPTH) ? 1 : 0);
        end
        bus.ld_note = 1'b0;

        // Randomized playback of recorded slots
        for (int r = 0; r < 8; r++) begin
            idx = AW'($urandom_range(0, DEPTH - 1));
            playStart(idx);
            checkOutput($sformatf("rand_cur_note_slot%0d", idx), bus.cur_note, mdlMem[idx]);
            hp  = expHp(int'(mdlMem[idx]));
            win = $urandom_range(1, 150);
            for (int m = 1; m <= win; m++) begin
                step(1);
                checkOutput($sformatf("rand_audio_slot%0d_m%0d", idx, m), bus.audio_out, expAudio(m, hp));
            end
        end
        bus.ld_play = 1'b0;
        step(2);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
